// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles the operand_fetch request, writeback, register-file
// and operand handshakes. Signal names keep the i_/o_ prefixes as seen from the
// operand_fetch block.
//   request  : i_req_valid, o_req_ready, i_rs1, i_rs2
//   writeback: i_wb_valid, o_wb_ready, i_wb_addr, i_wb_data
//   reg file : o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
//              i_rf_r1data, i_rf_r2data
//   operands : o_op_valid, i_op_ready, o_op1, o_op2
// Modports: slave (operand_fetch itself), master (its surroundings).
interface operand_fetch_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [4:0]  o_rf_r1addr;
  logic [4:0]  o_rf_r2addr;
  logic [31:0] i_rf_r1data;
  logic [31:0] i_rf_r2data;
  logic        o_op_valid;
  logic        i_op_ready;
  logic [31:0] o_op1;
  logic [31:0] o_op2;

  modport slave (
    input  i_req_valid, i_rs1, i_rs2,
    input  i_wb_valid, i_wb_addr, i_wb_data,
    input  i_rf_r1data, i_rf_r2data,
    input  i_op_ready,
    output o_req_ready, o_wb_ready,
    output o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
    output o_op_valid, o_op1, o_op2
  );

  modport master (
    output i_req_valid, i_rs1, i_rs2,
    output i_wb_valid, i_wb_addr, i_wb_data,
    output i_rf_r1data, i_rf_r2data,
    output i_op_ready,
    input  o_req_ready, o_wb_ready,
    input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
    input  o_op_valid, o_op1, o_op2
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: issue-side controller for a 32x32 register file with a
// one-cycle synchronous read, where a write cycle discards that cycle's reads.
// Latches rs1/rs2, retries the read until a write-free cycle, captures the
// operands (forwarding a same-cycle writeback), and holds them on a
// valid/ready handshake while keeping them coherent with later writebacks.
// x0 operands are always zero and never forwarded.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : operand_fetch_if.slave (request, writeback, reg file, operands)
// Build option: OPFETCH_STARVE_GUARD_EN -- after three consecutive READ cycles
// lost to writes, o_wb_ready drops for one cycle so the read completes.
module operand_fetch (
  input logic            i_clk,
  input logic            i_rst_n,
  operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DATA, S_VALID} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic        w_wb_ready;
  logic        w_wen;
  logic        w_req_ready;
  logic        w_op_valid;
  logic        w_accept;
  logic        w_fwd1;
  logic        w_fwd2;

`ifdef OPFETCH_STARVE_GUARD_EN
  logic [1:0] r_lost;

  // Counts consecutive READ cycles lost to writes; at 3 the write port is
  // closed, so the count can never wrap and clears as READ is left.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lost <= '0;
    end else if (r_state == S_READ && w_wen) begin
      r_lost <= r_lost + 2'd1;
    end else begin
      r_lost <= '0;
    end
  end

  always_comb w_wb_ready = i_rst_n && !(r_state == S_READ && r_lost == 2'd3);
`else
  always_comb w_wb_ready = i_rst_n;
`endif

  always_comb begin
    w_wen    = bus.i_wb_valid && w_wb_ready;
    w_fwd1   = w_wen && (bus.i_wb_addr != '0) && (bus.i_wb_addr == r_rs1);
    w_fwd2   = w_wen && (bus.i_wb_addr != '0) && (bus.i_wb_addr == r_rs2);
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_op_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = i_rst_n;
        if (bus.i_req_valid) w_next = S_READ;
      end
      S_READ: begin
        // A committed write drops this cycle's read, so retry.
        if (!w_wen) w_next = S_DATA;
      end
      S_DATA: w_next = S_VALID;
      S_VALID: begin
        w_op_valid  = 1'b1;
        w_req_ready = i_rst_n && bus.i_op_ready;
        if (bus.i_op_ready) w_next = bus.i_req_valid ? S_READ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    w_accept = bus.i_req_valid && w_req_ready;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rs1 <= bus.i_rs1;
        r_rs2 <= bus.i_rs2;
      end
      if (r_state == S_DATA) begin
        r_op1 <= (r_rs1 == '0) ? '0 : (w_fwd1 ? bus.i_wb_data : bus.i_rf_r1data);
        r_op2 <= (r_rs2 == '0) ? '0 : (w_fwd2 ? bus.i_wb_data : bus.i_rf_r2data);
      end else if (r_state == S_VALID) begin
        if (w_fwd1) r_op1 <= bus.i_wb_data;
        if (w_fwd2) r_op2 <= bus.i_wb_data;
      end
    end
  end

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_wb_ready  = w_wb_ready;
  assign bus.o_rf_wen    = w_wen;
  assign bus.o_rf_waddr  = bus.i_wb_addr;
  assign bus.o_rf_wdata  = bus.i_wb_data;
  assign bus.o_rf_r1addr = r_rs1;
  assign bus.o_rf_r2addr = r_rs2;
  assign bus.o_op_valid  = w_op_valid;
  assign bus.o_op1       = r_op1;
  assign bus.o_op2       = r_op2;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch. Contains a register
// file model (one-cycle synchronous read, reads dropped on write cycles), a
// vector table of single requests, hand sequences for hold/forwarding,
// starvation and mid-operation reset, and a randomized phase checked against an
// architectural register model. Honours OPFETCH_STARVE_GUARD_EN.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] arch   [32];
  logic [31:0] rf_mem [32];

  // Register file model: a write cycle discards that cycle's reads.
  always @(posedge clk) begin
    if (bus.o_rf_wen) begin
      rf_mem[bus.o_rf_waddr] <= bus.o_rf_wdata;
      bus.i_rf_r1data <= 32'hA5A5_0F0F;
      bus.i_rf_r2data <= 32'hA5A5_0F0F;
    end else begin
      bus.i_rf_r1data <= rf_mem[bus.o_rf_r1addr];
      bus.i_rf_r2data <= rf_mem[bus.o_rf_r2addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] arch_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : arch[a];
  endfunction

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0;
    bus.i_rs1       = '0;
    bus.i_rs2       = '0;
    bus.i_wb_valid  = 1'b0;
    bus.i_wb_addr   = '0;
    bus.i_wb_data   = '0;
    bus.i_op_ready  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = a;
    bus.i_wb_data  = d;
    @(posedge clk);
    if (a != 5'd0) arch[a] = d;
    #1 bus.i_wb_valid = 1'b0;
  endtask

  // One request from IDLE; optional single write presented in cycle wcyc after
  // the accepting edge (0 = the accepting cycle itself, -1 = none).
  task automatic do_req(input logic [4:0] a1, input logic [4:0] a2, input int wcyc,
                        input logic [4:0] wa, input logic [31:0] wd,
                        output int lat, output logic [31:0] r1, output logic [31:0] r2);
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = a1;
    bus.i_rs2 = a2;
    bus.i_wb_valid = (wcyc == 0);
    bus.i_wb_addr = wa;
    bus.i_wb_data = wd;
    @(posedge clk);
    if (wcyc == 0 && wa != 5'd0) arch[wa] = wd;
    lat = -1;
    r1 = '0;
    r2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      bus.i_wb_valid  = (wcyc == c);
      bus.i_op_ready  = 1'b0;
      #1;
      if (bus.o_op_valid) begin
        lat = c;
        r1 = bus.o_op1;
        r2 = bus.o_op2;
        bus.i_op_ready = 1'b1;
      end
      @(posedge clk);
      if (wcyc == c && wa != 5'd0) arch[wa] = wd;
      if (lat >= 0) break;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    int          wcyc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    int          elat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    int vcnt;
    logic [31:0] r1, r2;
    // random-phase model
    bit pend, rdone, attempt, exp_valid, exp_wbr, exp_rr, wen;
    int lost, since;
    logic [4:0] m_rs1, m_rs2;

    vecs[0] = '{5'd5,  5'd6, -1, 5'd0, 32'h0,         32'h1111_1111, 32'h2222_2222, 3};
    vecs[1] = '{5'd0,  5'd7,  2, 5'd0, 32'h5A5A_5A5A, 32'h0,         32'hDEAD_BEEF, 3};
    vecs[2] = '{5'd3,  5'd6,  1, 5'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h2222_2222, 4};
    vecs[3] = '{5'd7,  5'd7,  2, 5'd7, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 3};
    vecs[4] = '{5'd9,  5'd0,  0, 5'd9, 32'h9999_9999, 32'h9999_9999, 32'h0,         3};
    vecs[5] = '{5'd31, 5'd1, -1, 5'd0, 32'h0,         32'h3131_3131, 32'h0101_0101, 3};
    vecs[6] = '{5'd0,  5'd0,  0, 5'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,         3};
    vecs[7] = '{5'd2,  5'd3,  2, 5'd4, 32'h4444_4444, 32'h1000_0002, 32'hCAFE_F00D, 3};

    // ---- reset ----
    rst_n = 1'b0;
    idle_inputs();
    bus.i_wb_valid = 1'b1;
    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_op_valid",  {31'b0, bus.o_op_valid},  32'h0);
    chk("rst_op1",       bus.o_op1,                32'h0);
    chk("rst_op2",       bus.o_op2,                32'h0);
    chk("rst_r1addr",    {27'b0, bus.o_rf_r1addr}, 32'h0);
    chk("rst_req_ready", {31'b0, bus.o_req_ready}, 32'h0);
    chk("rst_wb_ready",  {31'b0, bus.o_wb_ready},  32'h0);
    chk("rst_rf_wen",    {31'b0, bus.o_rf_wen},    32'h0);
    bus.i_wb_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'b0, bus.o_req_ready}, 32'h1);
    chk("post_rst_wb_ready",  {31'b0, bus.o_wb_ready},  32'h1);

    // ---- preload the register file through the writeback port ----
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = 32'h1000_0000 + 32'(i);
      if (i == 1)  v = 32'h0101_0101;
      if (i == 5)  v = 32'h1111_1111;
      if (i == 6)  v = 32'h2222_2222;
      if (i == 7)  v = 32'hDEAD_BEEF;
      if (i == 31) v = 32'h3131_3131;
      wr(5'(i), v);
    end

    // ---- vector table ----
    for (int k = 0; k < 8; k++) begin
      do_req(vecs[k].rs1, vecs[k].rs2, vecs[k].wcyc, vecs[k].wa, vecs[k].wd, lat, r1, r2);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].elat));
      chk($sformatf("vec%0d_op1", k), r1, vecs[k].e1);
      chk($sformatf("vec%0d_op2", k), r2, vecs[k].e2);
    end

    // ---- held operands follow a later writeback ----
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = 5'd5;
    bus.i_rs2 = 5'd6;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      #1;
      if (bus.o_op_valid) begin
        lat = c;
        break;
      end
    end
    chk("hold_latency", 32'(lat), 32'd3);
    chk("hold_op1_before", bus.o_op1, 32'h1111_1111);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd5;
    bus.i_wb_data  = 32'h0BAD_F00D;
    #1;
    chk("hold_op1_same_cycle", bus.o_op1, 32'h1111_1111);
    @(posedge clk);
    arch[5] = 32'h0BAD_F00D;
    @(negedge clk);
    bus.i_wb_valid = 1'b0;
    #1;
    chk("hold_valid", {31'b0, bus.o_op_valid}, 32'h1);
    chk("hold_op1_fwd", bus.o_op1, 32'h0BAD_F00D);
    chk("hold_op2", bus.o_op2, 32'h2222_2222);
    bus.i_op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_op_ready = 1'b0;
    #1;
    chk("hold_released", {31'b0, bus.o_op_valid}, 32'h0);

    // ---- write starvation of the READ cycle ----
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = 5'd6;
    bus.i_rs2 = 5'd1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 14; c++) begin
      logic ewbr;
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      bus.i_wb_valid  = (c <= 8);
      bus.i_wb_addr   = 5'd20;
      bus.i_wb_data   = 32'(c);
      #1;
      ewbr = 1'b1;
`ifdef OPFETCH_STARVE_GUARD_EN
      if (c == 4) ewbr = 1'b0;
`endif
      if (c <= 8) chk($sformatf("starve_wb_ready_c%0d", c), {31'b0, bus.o_wb_ready}, {31'b0, ewbr});
      if (bus.o_op_valid) begin
        lat = c;
        chk("starve_op1", bus.o_op1, 32'h2222_2222);
        chk("starve_op2", bus.o_op2, 32'h0101_0101);
        bus.i_op_ready = 1'b1;
        @(posedge clk);
        break;
      end
    end
`ifdef OPFETCH_STARVE_GUARD_EN
    chk("starve_latency", 32'(lat), 32'd6);
`else
    chk("starve_latency", 32'(lat), 32'd11);
`endif
    @(negedge clk);
    idle_inputs();

    // ---- reset during DATA ----
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = 5'd5;
    bus.i_rs2 = 5'd6;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd5;
    bus.i_wb_data  = 32'hEEEE_EEEE;
    #1;
    chk("mid_rst_wb_ready",  {31'b0, bus.o_wb_ready},  32'h0);
    chk("mid_rst_rf_wen",    {31'b0, bus.o_rf_wen},    32'h0);
    chk("mid_rst_req_ready", {31'b0, bus.o_req_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_rst_op_valid", {31'b0, bus.o_op_valid},  32'h0);
    chk("mid_rst_op1",      bus.o_op1,                32'h0);
    chk("mid_rst_op2",      bus.o_op2,                32'h0);
    chk("mid_rst_r2addr",   {27'b0, bus.o_rf_r2addr}, 32'h0);
    rst_n = 1'b1;
    bus.i_wb_valid = 1'b0;
    #1;
    chk("mid_rst_req_ready_after", {31'b0, bus.o_req_ready}, 32'h1);
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.o_op_valid) vcnt++;
    end
    chk("mid_rst_no_output", 32'(vcnt), 32'h0);

    // ---- randomized traffic against the architectural model ----
    pend = 1'b0; rdone = 1'b0; lost = 0; since = 0;
    m_rs1 = '0; m_rs2 = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      bit drain;
      drain = (cyc >= 860);
      @(negedge clk);
      bus.i_req_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
      bus.i_rs1       = 5'($urandom_range(0, 7));
      bus.i_rs2       = 5'($urandom_range(0, 7));
      bus.i_wb_valid  = drain ? 1'b0 : ($urandom_range(0, 9) < 4);
      bus.i_wb_addr   = 5'($urandom_range(0, 7));
      bus.i_wb_data   = $urandom;
      bus.i_op_ready  = drain ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      attempt   = pend && !rdone;
      exp_valid = pend && rdone && (since >= 2);
      exp_wbr   = 1'b1;
`ifdef OPFETCH_STARVE_GUARD_EN
      if (attempt && lost == 3) exp_wbr = 1'b0;
`endif
      exp_rr = !pend || (exp_valid && bus.i_op_ready);
      wen    = bus.i_wb_valid && exp_wbr;
      chk("rnd_op_valid",  {31'b0, bus.o_op_valid},  {31'b0, exp_valid});
      chk("rnd_wb_ready",  {31'b0, bus.o_wb_ready},  {31'b0, exp_wbr});
      chk("rnd_req_ready", {31'b0, bus.o_req_ready}, {31'b0, exp_rr});
      chk("rnd_rf_wen",    {31'b0, bus.o_rf_wen},    {31'b0, wen});
      if (bus.i_wb_valid) chk("rnd_rf_wdata", bus.o_rf_wdata, bus.i_wb_data);
      if (pend) chk("rnd_rf_raddr", {22'b0, bus.o_rf_r1addr, bus.o_rf_r2addr}, {22'b0, m_rs1, m_rs2});
      if (exp_valid) begin
        chk("rnd_op1", bus.o_op1, arch_rd(m_rs1));
        chk("rnd_op2", bus.o_op2, arch_rd(m_rs2));
      end
      // model update for the coming edge
      if (attempt) begin
        if (wen) lost++;
        else begin
          rdone = 1'b1;
          since = 1;
        end
      end else if (pend && rdone && since < 2) begin
        since++;
      end
      if (exp_valid && bus.i_op_ready) pend = 1'b0;
      if (bus.i_req_valid && exp_rr) begin
        pend = 1'b1; rdone = 1'b0; lost = 0; since = 0;
        m_rs1 = bus.i_rs1;
        m_rs2 = bus.i_rs2;
      end
      if (wen && bus.i_wb_addr != 5'd0) arch[bus.i_wb_addr] = bus.i_wb_data;
      @(posedge clk);
    end
    chk("rnd_drained", {31'b0, pend}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
